// File: rtl/uart_test.sv
// uart_test: board UART self-test that sends "HELLO ALINX\r\n" once per WAIT_CYCLES and echoes received bytes.
// Optional feature macro UART_ECHO_EN: when defined, builds the 8N1 receiver, echo buffer and echo path.
`timescale 1ns/1ps
module uart_test #(
    parameter int CLK_FRE     = 50,
    parameter int BAUD_RATE   = 115200,
    parameter int WAIT_CYCLES = 50_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic uart_tx
);
    localparam int CYCLE     = CLK_FRE * 1_000_000 / BAUD_RATE;
    localparam int HALF      = CYCLE / 2;
    localparam int NUM_BYTES = 13;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {C_IDLE, C_SEND, C_WAIT} ctrl_state_t;

    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        buf_full;
    logic [7:0]  buf_data;
    logic        buf_drain;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    assign tx_ready = (tx_state == TX_IDLE);

    // The stop bit's final clock is spent in TX_IDLE, so a load there chains frames with no gap.
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_load) begin
                    tx_state <= TX_START;
                    tx_shift <= tx_data;
                    tx_cnt   <= 16'(CYCLE - 1);
                    uart_tx  <= 1'b0;
                end
                TX_START: if (tx_cnt == '0) begin
                    tx_state <= TX_DATA;
                    tx_bit   <= '0;
                    tx_cnt   <= 16'(CYCLE - 1);
                    uart_tx  <= tx_shift[0];
                end else tx_cnt <= tx_cnt - 16'd1;
                TX_DATA: if (tx_cnt == '0) begin
                    if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        tx_cnt   <= 16'(CYCLE - 2);
                        uart_tx  <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_cnt   <= 16'(CYCLE - 1);
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        uart_tx  <= tx_shift[1];
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                TX_STOP: if (tx_cnt == '0) tx_state <= TX_IDLE;
                         else tx_cnt <= tx_cnt - 16'd1;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef UART_ECHO_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state;
    logic        rx_q1, rx_s, rx_d;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_err;
    logic        rx_valid;

    // rx_err holds the receiver in RX_STOP after a framing error until the line returns high.
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            rx_q1    <= 1'b1;
            rx_s     <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_err   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_q1    <= uart_rx;
            rx_s     <= rx_q1;
            rx_d     <= rx_s;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_d && !rx_s) begin
                    rx_state <= RX_START;
                    rx_cnt   <= 16'(HALF - 1);
                end
                RX_START: if (rx_cnt == '0) begin
                    if (rx_s) rx_state <= RX_IDLE;
                    else begin
                        rx_state <= RX_DATA;
                        rx_bit   <= '0;
                        rx_cnt   <= 16'(CYCLE - 1);
                    end
                end else rx_cnt <= rx_cnt - 16'd1;
                RX_DATA: if (rx_cnt == '0) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_cnt   <= 16'(CYCLE - 1);
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                RX_STOP: if (rx_err) begin
                    if (rx_s) begin
                        rx_err   <= 1'b0;
                        rx_state <= RX_IDLE;
                    end
                end else if (rx_cnt == '0) begin
                    if (rx_s) begin
                        rx_valid <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else rx_err <= 1'b1;
                end else rx_cnt <= rx_cnt - 16'd1;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (rx_valid) begin
            buf_full <= 1'b1;
            buf_data <= rx_shift;
        end else if (buf_drain) begin
            buf_full <= 1'b0;
        end
    end
`else
    logic unused_echo;
    assign buf_full    = 1'b0;
    assign buf_data    = 8'h00;
    assign unused_echo = ^{uart_rx, buf_drain};
`endif

    // ctrl: C_IDLE = just out of reset | C_SEND = greeting bytes | C_WAIT = gap timer + echo service
    ctrl_state_t c_state, c_next;
    logic [3:0]  idx;
    logic [31:0] wait_cnt;

    function automatic logic [7:0] greeting(input logic [3:0] i);
        case (i)
            4'd0:  greeting = 8'h48;
            4'd1:  greeting = 8'h45;
            4'd2:  greeting = 8'h4C;
            4'd3:  greeting = 8'h4C;
            4'd4:  greeting = 8'h4F;
            4'd5:  greeting = 8'h20;
            4'd6:  greeting = 8'h41;
            4'd7:  greeting = 8'h4C;
            4'd8:  greeting = 8'h49;
            4'd9:  greeting = 8'h4E;
            4'd10: greeting = 8'h58;
            4'd11: greeting = 8'h0D;
            default: greeting = 8'h0A;
        endcase
    endfunction

    always_comb begin
        c_next    = c_state;
        tx_load   = 1'b0;
        tx_data   = greeting(idx);
        buf_drain = 1'b0;
        case (c_state)
            C_IDLE: c_next = C_SEND;
            C_SEND: if (tx_ready) begin
                if (idx == 4'(NUM_BYTES)) c_next = C_WAIT;
                else tx_load = 1'b1;
            end
            C_WAIT: if (wait_cnt == '0) begin
                if (tx_ready) c_next = C_SEND;
            end else if (buf_full && tx_ready) begin
                tx_load   = 1'b1;
                tx_data   = buf_data;
                buf_drain = 1'b1;
            end
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            c_state  <= C_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            c_state <= c_next;
            if (c_state == C_SEND && tx_load) idx <= idx + 4'd1;
            if (c_state == C_SEND && c_next == C_WAIT) begin
                idx      <= '0;
                wait_cnt <= 32'(WAIT_CYCLES - 1);
            end else if (c_state == C_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_test.sv
// tb_uart_test: directed bench for uart_test -- greeting content/timing, idle gap, echo, false start, mid-frame reset.
`timescale 1ns/1ps
module tb_uart_test;
    localparam int CYCLE = 434;
    localparam int HALF  = 217;
    localparam int WAIT  = 20_000;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_last   = 0;

    logic [7:0] exp_greet [13] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h41,
                                   8'h4C, 8'h49, 8'h4E, 8'h58, 8'h0D, 8'h0A};

    uart_test #(.CLK_FRE(50), .BAUD_RATE(115200), .WAIT_CYCLES(WAIT)) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic wait_tx_fall(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (uart_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic decode_tx(output logic [7:0] b, output logic framing_ok);
        logic s0;
        repeat (HALF) @(negedge sys_clk);
        s0 = uart_tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CYCLE) @(negedge sys_clk);
            b[i] = uart_tx;
        end
        repeat (CYCLE) @(negedge sys_clk);
        framing_ok = (s0 === 1'b0) && (uart_tx === 1'b1);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (CYCLE) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CYCLE) @(negedge sys_clk);
        end
        uart_rx = stop;
        repeat (CYCLE) @(negedge sys_clk);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        int t0;
        rst_n   = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx_idle: got %b expected 1", uart_tx);
        end
        rst_n = 1'b0;
        t0 = cyc;
        wait_tx_fall(2, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL first_start_latency: no start bit within 2 clocks (got %0d clocks) expected <= 2", cyc - t0);
        end
        t_last = cyc;
    endtask

    task automatic test_greeting();
        bit ok;
        logic [7:0] b;
        logic fr;
        int t_prev;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) begin
                t_prev = t_last;
                wait_tx_fall(600, ok);
                t_last = cyc;
                n_checks++;
                if (ok !== 1'b1 || (t_last - t_prev) != 4340) begin
                    n_fail++;
                    $display("FAIL greet_spacing[%0d]: got %0d clocks expected 4340", k, t_last - t_prev);
                end
            end
            decode_tx(b, fr);
            n_checks++;
            if (b !== exp_greet[k] || fr !== 1'b1) begin
                n_fail++;
                $display("FAIL greet_byte[%0d]: got %h framing %b expected %h framing 1", k, b, fr, exp_greet[k]);
            end
        end
    endtask

    task automatic test_false_start();
        int lows;
        uart_rx = 1'b0;
        #100;
        uart_rx = 1'b1;
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL false_start_quiet: got %0d low samples expected 0", lows);
        end
    endtask

    task automatic test_echo();
        int c0;
        c0 = cyc;
        fork
            begin
                drive_rx(8'hA3, 1'b1);
                drive_rx(8'hA3, 1'b0);
                repeat (20) @(negedge sys_clk);
                drive_rx(8'h55, 1'b1);
            end
            begin
`ifdef UART_ECHO_EN
                bit ok;
                logic [7:0] b;
                logic fr;
                int lat;
                wait_tx_fall(5000, ok);
                lat = cyc - c0;
                n_checks++;
                if (ok !== 1'b1 || lat < 4123 || lat > 4557) begin
                    n_fail++;
                    $display("FAIL echo_a3_latency: got %0d clocks expected 4123..4557", lat);
                end
                decode_tx(b, fr);
                n_checks++;
                if (b !== 8'hA3 || fr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL echo_a3_byte: got %h framing %b expected a3 framing 1", b, fr);
                end
                wait_tx_fall(6000, ok);
                lat = cyc - (c0 + 8700);
                n_checks++;
                if (ok !== 1'b1 || lat < 4123 || lat > 4557) begin
                    n_fail++;
                    $display("FAIL echo_55_latency: got %0d clocks expected 4123..4557", lat);
                end
                decode_tx(b, fr);
                n_checks++;
                if (b !== 8'h55 || fr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL echo_55_byte: got %h framing %b expected 55 framing 1", b, fr);
                end
`else
                int lows;
                lows = 0;
                for (int i = 0; i < 16000; i++) begin
                    @(negedge sys_clk);
                    if (uart_tx !== 1'b1) lows++;
                end
                n_checks++;
                if (lows != 0) begin
                    n_fail++;
                    $display("FAIL no_echo_quiet: got %0d low samples expected 0", lows);
                end
`endif
            end
        join
    endtask

    task automatic test_gap();
        bit ok;
        logic [7:0] b;
        logic fr;
        int gap;
        wait_tx_fall(10000, ok);
        gap = cyc - t_last - 4340;
        n_checks++;
        if (ok !== 1'b1 || gap < WAIT || gap > WAIT + 2) begin
            n_fail++;
            $display("FAIL idle_gap: got %0d clocks expected %0d..%0d", gap, WAIT, WAIT + 2);
        end
        decode_tx(b, fr);
        n_checks++;
        if (b !== 8'h48 || fr !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_first_byte: got %h framing %b expected 48 framing 1", b, fr);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [7:0] b;
        logic fr;
        wait_tx_fall(600, ok);
        repeat (100) @(negedge sys_clk);
        n_checks++;
        if (ok !== 1'b1 || uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_start_bit: got %b expected 0", uart_tx);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_reset_tx: got %b expected 1", uart_tx);
        end
        repeat (4) @(negedge sys_clk);
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_tx: got %b expected 1", uart_tx);
        end
        rst_n = 1'b0;
        wait_tx_fall(2, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_latency: got no start bit expected within 2 clocks");
        end
        decode_tx(b, fr);
        n_checks++;
        if (b !== 8'h48 || fr !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_byte: got %h framing %b expected 48 framing 1", b, fr);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_greeting();
        test_false_start();
        test_echo();
        test_gap();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
